cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning width of angle and x/y data.
REQ-002 SHALL have parameter STAGES, default 16, meaning the number of cordic pipeline stages driven.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid; requester i = bit i.
REQ-006 SHALL have port req_ready  output  2  per-requester request accepted this cycle when valid.
REQ-007 SHALL have port req_mode  input  2  per-requester mode: 0 = rotation, 1 = vectoring.
REQ-008 SHALL have ports req_angle, req_x, req_y  input  2*BIT_WIDTH each  per-requester operands; requester i occupies slice [i*BIT_WIDTH +: BIT_WIDTH].
REQ-009 SHALL have port rsp_valid  output  2  one-hot response valid, routed to the issuing requester.
REQ-010 SHALL have port rsp_ready  input  2  per-requester response ready.
REQ-011 SHALL have ports rsp_x, rsp_y  output  BIT_WIDTH each, and rsp_angle  output  BIT_WIDTH+1  shared response data.
REQ-012 SHALL have port pipe_start  output  1  pipeline advance enable, fanned out to every stage.
REQ-013 SHALL have ports pipe_in_target_angle, pipe_in_x, pipe_in_y  output  BIT_WIDTH each; pipe_in_current_angle  output  BIT_WIDTH+1; pipe_in_mode, pipe_in_done  output  1 each: first-stage inputs.
REQ-014 SHALL have ports pipe_out_x, pipe_out_y  input  BIT_WIDTH each; pipe_out_angle  input  BIT_WIDTH+1; pipe_out_done  input  1: last-stage outputs.
REQ-015 SHALL have port busy  output  1  high while any operation is in flight.

Function
REQ-016 SHALL drive pipe_start = 0 only when pipe_out_done=1 and rsp_ready of the owning requester is 0 (stall); otherwise 1.
REQ-017 SHALL drive rsp_valid[tag] = pipe_out_done, where tag is the owner at the tail of the tag shift register; other bit 0.
REQ-018 SHALL drive rsp_x/rsp_y/rsp_angle directly from pipe_out_x/pipe_out_y/pipe_out_angle.
REQ-019 SHALL grant round-robin: when both valid, grant the requester not granted on the last accepted transfer; a single valid requester is always granted.
REQ-020 SHALL assert req_ready[i] only for the granted requester and only while pipe_start=1; at most one bit high.
REQ-021 SHALL update the round-robin pointer only on an accepted transfer (req_valid & req_ready).
REQ-022 SHALL mux the granted requester's operands combinationally onto pipe_in_*; pipe_in_done = 1 on accept, else 0.
REQ-023 SHALL drive pipe_in_current_angle = 0 for every operation.
REQ-024 SHALL keep a STAGES-deep tag shift register (1-bit owner + valid) advancing only on pipe_start=1, pushing the grant index on accept, and a bubble otherwise.
REQ-025 SHALL keep an in-flight counter 0..STAGES: +1 on accept, -1 on response handshake (rsp_valid & rsp_ready), unchanged when both or neither occur; busy = (counter != 0).
REQ-026 SHALL produce the response exactly STAGES clock edges after the accept edge, plus one cycle per stall cycle.
REQ-027 SHALL hold all pipe_in_* and req_ready = 0 during a stall; no request accepted while pipe_start=0.
REQ-028 SHALL allow accept and response handshake in the same cycle.

Reset
REQ-029 SHALL, during reset, drive req_ready=0, rsp_valid=0, pipe_in_done=0, busy=0, pipe_start=1 so stages clear; clear tag register, counter, and set round-robin pointer to prefer requester 0.
REQ-030 SHALL discard all in-flight operations on reset mid-operation; no response issues for them afterwards.

Verification
REQ-031 SHALL pass: requester 0 rotation, angle=2^(BIT_WIDTH-1), x=K-scaled 1, y=0, accepted cycle t -> rsp_valid=2'b01 at cycle t+16, x≈y within 2 LSB.
REQ-032 SHALL pass: both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1...; responses return in issue order with matching one-hot rsp_valid.
REQ-033 SHALL pass: rsp_ready[1]=0 for 5 cycles while requester 1's result is at the tail -> pipe_start=0 for 5 cycles, rsp data stable, req_ready=0, no result lost or duplicated.
REQ-034 SHALL pass: back-to-back 16 requests fill pipeline -> counter reaches 16, busy=1; drain -> busy=0 exactly one cycle after the last response handshake.
REQ-035 SHALL pass: reset asserted with 6 ops in flight -> next cycle rsp_valid=0, busy=0, and no response for those ops in the following 20 cycles.
REQ-036 SHALL pass: requester 1 vectoring x=y=2^(BIT_WIDTH-2) -> rsp_y≈0 within 2 LSB, rsp_angle≈2^(BIT_WIDTH-1).

Source files
------------

// File: rtl/cordic_sched.sv
// cordic_sched: round-robin front end that feeds two requesters into an external CORDIC pipeline and routes results back.
// Parameters: BIT_WIDTH (angle/x/y width), STAGES (external pipeline depth, >= 2).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready/req_mode     per-requester request handshake and mode (0 rotate, 1 vector)
//   req_angle/req_x/req_y            per-requester operands, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   rsp_valid/rsp_ready              one-hot response handshake, routed to the issuing requester
//   rsp_x/rsp_y/rsp_angle            shared response data taken straight from the last stage
//   pipe_start                       advance enable for every pipeline stage
//   pipe_in_*                        first-stage inputs
//   pipe_out_*                       last-stage outputs
//   busy                             high while any operation is in flight
module cordic_sched #(
    parameter int BIT_WIDTH = 16,
    parameter int STAGES    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_mode,
    input  logic [2*BIT_WIDTH-1:0] req_angle,
    input  logic [2*BIT_WIDTH-1:0] req_x,
    input  logic [2*BIT_WIDTH-1:0] req_y,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [BIT_WIDTH-1:0]   rsp_x,
    output logic [BIT_WIDTH-1:0]   rsp_y,
    output logic [BIT_WIDTH:0]     rsp_angle,
    output logic                   pipe_start,
    output logic [BIT_WIDTH-1:0]   pipe_in_target_angle,
    output logic [BIT_WIDTH:0]     pipe_in_current_angle,
    output logic [BIT_WIDTH-1:0]   pipe_in_x,
    output logic [BIT_WIDTH-1:0]   pipe_in_y,
    output logic                   pipe_in_mode,
    output logic                   pipe_in_done,
    input  logic [BIT_WIDTH-1:0]   pipe_out_x,
    input  logic [BIT_WIDTH-1:0]   pipe_out_y,
    input  logic [BIT_WIDTH:0]     pipe_out_angle,
    input  logic                   pipe_out_done,
    output logic                   busy
);
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] tag_v_q, tag_v_d, tag_o_q, tag_o_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt, tail_v, tail_o, stall, accept, rsp_hs;

    always_comb begin
        gnt    = &req_valid ? ~last_q : req_valid[1];
        // Stale done bits left in the stages after a reset carry no tag and are ignored.
        tail_v = tag_v_q[STAGES-1] & pipe_out_done & ~reset;
        tail_o = tag_o_q[STAGES-1];
        stall  = tail_v & ~rsp_ready[tail_o];
        rsp_hs = tail_v & rsp_ready[tail_o];
        pipe_start = ~stall;
        accept     = pipe_start & (|req_valid) & ~reset;
        req_ready  = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        rsp_valid  = tail_v ? (tail_o ? 2'b10 : 2'b01) : 2'b00;
        rsp_x      = pipe_out_x;
        rsp_y      = pipe_out_y;
        rsp_angle  = pipe_out_angle;
        pipe_in_target_angle  = gnt ? req_angle[BIT_WIDTH +: BIT_WIDTH] : req_angle[0 +: BIT_WIDTH];
        pipe_in_x             = gnt ? req_x[BIT_WIDTH +: BIT_WIDTH] : req_x[0 +: BIT_WIDTH];
        pipe_in_y             = gnt ? req_y[BIT_WIDTH +: BIT_WIDTH] : req_y[0 +: BIT_WIDTH];
        pipe_in_mode          = gnt ? req_mode[1] : req_mode[0];
        pipe_in_current_angle = '0;
        pipe_in_done          = accept;
        busy    = ~reset & (cnt_q != '0);
        // Tags travel in lockstep with the external stages so the tail owner matches pipe_out.
        tag_v_d = pipe_start ? {tag_v_q[STAGES-2:0], accept} : tag_v_q;
        tag_o_d = pipe_start ? {tag_o_q[STAGES-2:0], accept & gnt} : tag_o_q;
        cnt_d   = cnt_q + CW'(accept) - CW'(rsp_hs);
        last_d  = accept ? gnt : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q <= '0;
            tag_o_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            tag_v_q <= tag_v_d;
            tag_o_q <= tag_o_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: scoreboard bench for cordic_sched with a behavioural delay-line pipeline model.
module tb_cordic_sched;
    localparam int BW = 16;
    localparam int ST = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
    logic [2*BW-1:0]   req_angle, req_x, req_y;
    logic [BW-1:0]     rsp_x, rsp_y, pipe_in_target_angle, pipe_in_x, pipe_in_y, pipe_out_x, pipe_out_y;
    logic [BW:0]       rsp_angle, pipe_in_current_angle, pipe_out_angle;
    logic              pipe_start, pipe_in_mode, pipe_in_done, pipe_out_done, busy;

    cordic_sched #(.BIT_WIDTH(BW), .STAGES(ST)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_angle(req_angle), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_angle(rsp_angle),
        .pipe_start(pipe_start),
        .pipe_in_target_angle(pipe_in_target_angle), .pipe_in_current_angle(pipe_in_current_angle),
        .pipe_in_x(pipe_in_x), .pipe_in_y(pipe_in_y), .pipe_in_mode(pipe_in_mode), .pipe_in_done(pipe_in_done),
        .pipe_out_x(pipe_out_x), .pipe_out_y(pipe_out_y), .pipe_out_angle(pipe_out_angle),
        .pipe_out_done(pipe_out_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // External pipeline stand-in: STAGES registers with no reset, advancing on pipe_start.
    logic          pd[ST];
    logic [BW-1:0] px[ST], py[ST];
    logic [BW:0]   pa[ST];
    initial for (int i = 0; i < ST; i++) begin pd[i] = 1'b0; px[i] = '0; py[i] = '0; pa[i] = '0; end
    always @(posedge clk) if (pipe_start) begin
        pd[0] <= pipe_in_done;
        px[0] <= pipe_in_x;
        py[0] <= pipe_in_y;
        pa[0] <= {pipe_in_mode, pipe_in_target_angle} + pipe_in_current_angle;
        for (int i = 1; i < ST; i++) begin pd[i] <= pd[i-1]; px[i] <= px[i-1]; py[i] <= py[i-1]; pa[i] <= pa[i-1]; end
    end
    assign pipe_out_done  = pd[ST-1];
    assign pipe_out_x     = px[ST-1];
    assign pipe_out_y     = py[ST-1];
    assign pipe_out_angle = pa[ST-1];

    typedef struct {
        logic          own;
        logic [BW-1:0] x, y;
        logic [BW:0]   a;
        int            acc, st;
    } op_t;
    op_t q[$];

    int checks = 0, errors = 0, cyc = 0, stalls = 0;
    logic last = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: an op accepted in cycle c appears in cycle c+STAGES plus every stall cycle since.
    always @(negedge clk) begin
        logic present, own, stl, g, acc;
        op_t e;
        if (reset) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_pipe_start", pipe_start, 1);
            chk("rst_busy", busy, 0);
            chk("rst_pipe_in_done", pipe_in_done, 0);
            q.delete();
            last = 1'b1;
        end else begin
            chk("busy", busy, q.size() != 0);
            present = q.size() > 0 && cyc >= q[0].acc + ST + (stalls - q[0].st);
            own = present ? q[0].own : 1'b0;
            chk("rsp_valid", rsp_valid, present ? (own ? 2'b10 : 2'b01) : 2'b00);
            stl = present && !rsp_ready[own];
            chk("pipe_start", pipe_start, !stl);
            if (present) begin
                chk("rsp_x", rsp_x, q[0].x);
                chk("rsp_y", rsp_y, q[0].y);
                chk("rsp_angle", rsp_angle, q[0].a);
                if (rsp_ready[own]) void'(q.pop_front());
            end
            g = &req_valid ? ~last : req_valid[1];
            acc = !stl && |req_valid;
            chk("req_ready", req_ready, acc ? (g ? 2'b10 : 2'b01) : 2'b00);
            chk("pipe_in_done", pipe_in_done, acc);
            chk("pipe_in_current_angle", pipe_in_current_angle, 0);
            if (acc) begin
                e.own = g;
                e.x = req_x[g*BW +: BW];
                e.y = req_y[g*BW +: BW];
                e.a = {req_mode[g], req_angle[g*BW +: BW]};
                e.acc = cyc;
                e.st = stalls;
                q.push_back(e);
                last = g;
            end
            if (stl) stalls++;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_ops();
        req_angle = (2*BW)'($urandom);
        req_x     = (2*BW)'($urandom);
        req_y     = (2*BW)'($urandom);
        req_mode  = 2'($urandom);
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 0; rsp_ready = 2'b11; rnd_ops();
        repeat (3) step();
        reset = 1'b0;
        step();
        // Single rotation request from requester 0.
        req_valid = 2'b01; req_mode = 2'b00;
        req_angle = {16'h0, 16'h8000}; req_x = {16'h0, 16'h4DBA}; req_y = '0;
        step();
        req_valid = 0;
        repeat (20) step();
        // Both requesters continuously valid.
        req_valid = 2'b11;
        repeat (8) begin rnd_ops(); step(); end
        req_valid = 0;
        repeat (24) step();
        // Requester 1 result held at the tail for five cycles, requester 0 op behind it.
        req_valid = 2'b10; rnd_ops(); step();
        req_valid = 2'b01; rnd_ops(); step();
        req_valid = 0;
        n = 0;
        while (!rsp_valid[1] && n < 40) begin step(); n++; end
        if (!rsp_valid[1]) begin
            errors++;
            $display("FAIL stall_wait: rsp_valid[1] never rose within 40 cycles");
        end
        rsp_ready = 2'b01; req_valid = 2'b01;
        repeat (5) step();
        rsp_ready = 2'b11; req_valid = 0;
        repeat (24) step();
        // Sixteen back-to-back requests fill the pipeline, then drain.
        req_valid = 2'b01;
        repeat (16) begin rnd_ops(); step(); end
        req_valid = 0;
        repeat (24) step();
        // Reset with six operations in flight.
        req_valid = 2'b11;
        repeat (6) begin rnd_ops(); step(); end
        req_valid = 0; reset = 1'b1; step();
        reset = 1'b0;
        repeat (20) step();
        // Randomized traffic with random backpressure.
        repeat (400) begin
            rnd_ops();
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
            step();
        end
        req_valid = 0; rsp_ready = 2'b11;
        repeat (40) step();
        chk("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
